// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mips_ctrl_pkg : opcodes, mux encodings and FSM states for the MCU.  |
// | Macro MCU_BNE_EN enables bne decode.                 Rev 1.0        |
// +--------------------------------------------------------------------+
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

`ifdef MCU_BNE_EN
  localparam bit BNE_EN = 1'b1;
`else
  localparam bit BNE_EN = 1'b0;
`endif

  typedef logic [3:0] state_t;

  localparam state_t S_IDLE     = 4'd0;
  localparam state_t S_FETCH    = 4'd1;
  localparam state_t S_DECODE   = 4'd2;
  localparam state_t S_MEMADR   = 4'd3;
  localparam state_t S_MEMREAD  = 4'd4;
  localparam state_t S_MEMWB    = 4'd5;
  localparam state_t S_MEMWRITE = 4'd6;
  localparam state_t S_EXECUTE  = 4'd7;
  localparam state_t S_ALUWB    = 4'd8;
  localparam state_t S_ADDIEX   = 4'd9;
  localparam state_t S_ADDIWB   = 4'd10;
  localparam state_t S_BRANCH   = 4'd11;
  localparam state_t S_JUMP     = 4'd12;

  // Successor of DECODE; S_FETCH doubles as the "unsupported opcode" result.
  function automatic state_t decode_target(input logic [5:0] op);
    case (op)
      OP_RTYPE:     return S_EXECUTE;
      OP_LW, OP_SW: return S_MEMADR;
      OP_ADDI:      return S_ADDIEX;
      OP_BEQ:       return S_BRANCH;
      OP_J:         return S_JUMP;
      OP_BNE:       return BNE_EN ? S_BRANCH : S_FETCH;
      default:      return S_FETCH;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_control_unit_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | multicycle_control_unit_if : opcode/handshake in, datapath controls |
// | out. BranchNe exists only with MCU_BNE_EN.           Rev 1.0        |
// +--------------------------------------------------------------------+
interface multicycle_control_unit_if #(
  parameter int OPCODE_W = 6
);
  logic [OPCODE_W-1:0] opcode;
  logic                mem_ready;
  logic                PCWrite;
  logic                Branch;
  logic                IorD;
  logic                MemRead;
  logic                MemWrite;
  logic                IRWrite;
  logic                RegDst;
  logic                MemtoReg;
  logic                RegWrite;
  logic                ALUSrcA;
  logic [1:0]          ALUSrcB;
  logic [1:0]          ALUOp;
  logic [1:0]          PCSrc;
  logic                illegal_op;
  logic                mem_err;
  logic [3:0]          state_o;
`ifdef MCU_BNE_EN
  logic                BranchNe;
`endif

  modport master (
    input  opcode, mem_ready,
    output PCWrite, Branch, IorD, MemRead, MemWrite, IRWrite, RegDst,
           MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSrc,
           illegal_op, mem_err, state_o
`ifdef MCU_BNE_EN
           , BranchNe
`endif
  );

  modport slave (
    output opcode, mem_ready,
    input  PCWrite, Branch, IorD, MemRead, MemWrite, IRWrite, RegDst,
           MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSrc,
           illegal_op, mem_err, state_o
`ifdef MCU_BNE_EN
           , BranchNe
`endif
  );
endinterface
`default_nettype wire

// File: rtl/mcu_wait_timer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mcu_wait_timer : counts stalled cycles, flags timeout at WAIT_MAX.  |
// |                                                      Rev 1.0        |
// +--------------------------------------------------------------------+
module mcu_wait_timer #(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = $clog2(WAIT_MAX + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic waiting,
  input  logic mem_ready,
  input  logic restart,
  output logic timeout
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WAIT_MAX - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign timeout = waiting && !mem_ready && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (restart)
      cnt_d = '0;
    else if (waiting && !mem_ready)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end
endmodule
`default_nettype wire

// File: rtl/multicycle_control_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | multicycle_control_unit : Moore FSM sequencing the MIPS multicycle  |
// | datapath; MCU_BNE_EN adds bne/BranchNe.              Rev 1.0        |
// +--------------------------------------------------------------------+
module multicycle_control_unit
  import mips_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = $clog2(WAIT_MAX + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  multicycle_control_unit_if.master bus
);
  state_t              state_q, state_d;
  logic                mem_err_q, mem_err_d;
  logic                waiting, timeout, restart;
  logic [OPCODE_W-1:0] op;

  assign op      = bus.opcode;
  assign waiting = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
  // A FETCH timeout keeps the state, so the counter must also restart on abort.
  assign restart = (state_d != state_q) || timeout;

  mcu_wait_timer #(
    .WAIT_MAX (WAIT_MAX),
    .CNT_W    (CNT_W)
  ) u_wait_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .waiting   (waiting),
    .mem_ready (bus.mem_ready),
    .restart   (restart),
    .timeout   (timeout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mem_err_q <= mem_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mem_err_d = timeout;
    case (state_q)
      S_IDLE:     state_d = S_FETCH;
      S_FETCH:    state_d = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:   state_d = decode_target(op);
      S_MEMADR:   state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = bus.mem_ready ? S_MEMWB : (timeout ? S_FETCH : S_MEMREAD);
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = (bus.mem_ready || timeout) ? S_FETCH : S_MEMWRITE;
      S_EXECUTE:  state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_ADDIEX:   state_d = S_ADDIWB;
      S_ADDIWB:   state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JUMP:     state_d = S_FETCH;
      default:    state_d = S_IDLE;
    endcase
  end

  assign bus.state_o = state_q;
  assign bus.mem_err = mem_err_q;

  always_comb begin
    bus.PCWrite    = 1'b0;
    bus.Branch     = 1'b0;
    bus.IorD       = 1'b0;
    bus.MemRead    = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.RegDst     = 1'b0;
    bus.MemtoReg   = 1'b0;
    bus.RegWrite   = 1'b0;
    bus.ALUSrcA    = 1'b0;
    bus.ALUSrcB    = SRCB_RT;
    bus.ALUOp      = ALUOP_ADD;
    bus.PCSrc      = PCSRC_ALU;
    bus.illegal_op = 1'b0;
`ifdef MCU_BNE_EN
    bus.BranchNe   = 1'b0;
`endif
    case (state_q)
      S_FETCH: begin
        bus.MemRead = 1'b1;
        bus.ALUSrcB = SRCB_FOUR;
        bus.IRWrite = bus.mem_ready;
        bus.PCWrite = bus.mem_ready;
      end
      S_DECODE: begin
        bus.ALUSrcB    = SRCB_IMM_SH;
        bus.illegal_op = (decode_target(op) == S_FETCH);
      end
      S_MEMADR, S_ADDIEX: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD: begin
        bus.IorD    = 1'b1;
        bus.MemRead = 1'b1;
      end
      S_MEMWB: begin
        bus.MemtoReg = 1'b1;
        bus.RegWrite = 1'b1;
      end
      S_MEMWRITE: begin
        bus.IorD     = 1'b1;
        bus.MemWrite = 1'b1;
      end
      S_EXECUTE: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUOp   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        bus.RegDst   = 1'b1;
        bus.RegWrite = 1'b1;
      end
      S_ADDIWB: bus.RegWrite = 1'b1;
      S_BRANCH: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUOp   = ALUOP_SUB;
        bus.PCSrc   = PCSRC_ALUOUT;
`ifdef MCU_BNE_EN
        bus.Branch   = (op == OP_BEQ);
        bus.BranchNe = (op == OP_BNE);
`else
        bus.Branch   = 1'b1;
`endif
      end
      S_JUMP: begin
        bus.PCSrc   = PCSRC_JUMP;
        bus.PCWrite = 1'b1;
      end
      default: ;
    endcase
  end
endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_multicycle_control_unit : scoreboard bench, instruction-plan     |
// | reference model, directed then random stimulus.      Rev 1.0        |
// +--------------------------------------------------------------------+
module tb_multicycle_control_unit;
  import mips_ctrl_pkg::*;

  localparam int WAIT_MAX = 4;
`ifdef MCU_BNE_EN
  localparam bit TB_BNE = 1'b1;
`else
  localparam bit TB_BNE = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multicycle_control_unit_if #(.OPCODE_W(6)) bus ();

  multicycle_control_unit #(
    .OPCODE_W (6),
    .WAIT_MAX (WAIT_MAX)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [3:0]  st;
    logic [18:0] ctrl;
  } exp_t;

  exp_t       sb_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [3:0] plan[$];
  int         m_wait;
  logic       m_err;
  logic [5:0] cur_op;
  logic [5:0] op_tbl[8] = '{6'b000000, 6'b100011, 6'b101011, 6'b001000,
                            6'b000100, 6'b000010, 6'b000101, 6'b111111};

  function automatic logic is_legal(input logic [5:0] op);
    return (op inside {6'b000000, 6'b100011, 6'b101011, 6'b001000, 6'b000100, 6'b000010})
           || (TB_BNE && op == 6'b000101);
  endfunction

  // Bit order: PCWrite Branch IorD MemRead MemWrite IRWrite RegDst MemtoReg
  // RegWrite ALUSrcA ALUSrcB ALUOp PCSrc illegal_op mem_err BranchNe
  function automatic logic [18:0] pk(input logic pcw, br, iord, mr, mw, irw, rdst, m2r, rw, srca,
                                     input logic [1:0] srcb, aluop, pcsrc, input logic ill, bne);
    return {pcw, br, iord, mr, mw, irw, rdst, m2r, rw, srca, srcb, aluop, pcsrc, ill, 1'b0, bne};
  endfunction

  function automatic logic [18:0] expect_ctrl(input logic [3:0] ph, input logic rdy,
                                              input logic [5:0] op, input logic err);
    logic [18:0] v;
    logic        z;
    z = 1'b0;
    case (ph)
      S_FETCH:    v = pk(rdy, z, z, 1'b1, z, rdy, z, z, z, z, 2'b01, 2'b00, 2'b00, z, z);
      S_DECODE:   v = pk(z, z, z, z, z, z, z, z, z, z, 2'b11, 2'b00, 2'b00, !is_legal(op), z);
      S_MEMADR:   v = pk(z, z, z, z, z, z, z, z, z, 1'b1, 2'b10, 2'b00, 2'b00, z, z);
      S_MEMREAD:  v = pk(z, z, 1'b1, 1'b1, z, z, z, z, z, z, 2'b00, 2'b00, 2'b00, z, z);
      S_MEMWB:    v = pk(z, z, z, z, z, z, z, 1'b1, 1'b1, z, 2'b00, 2'b00, 2'b00, z, z);
      S_MEMWRITE: v = pk(z, z, 1'b1, z, 1'b1, z, z, z, z, z, 2'b00, 2'b00, 2'b00, z, z);
      S_EXECUTE:  v = pk(z, z, z, z, z, z, z, z, z, 1'b1, 2'b00, 2'b10, 2'b00, z, z);
      S_ALUWB:    v = pk(z, z, z, z, z, z, 1'b1, z, 1'b1, z, 2'b00, 2'b00, 2'b00, z, z);
      S_ADDIEX:   v = pk(z, z, z, z, z, z, z, z, z, 1'b1, 2'b10, 2'b00, 2'b00, z, z);
      S_ADDIWB:   v = pk(z, z, z, z, z, z, z, z, 1'b1, z, 2'b00, 2'b00, 2'b00, z, z);
      S_BRANCH:   v = pk(z, TB_BNE ? (op == 6'b000100) : 1'b1, z, z, z, z, z, z, z, 1'b1,
                         2'b00, 2'b01, 2'b01, z, TB_BNE && (op == 6'b000101));
      S_JUMP:     v = pk(1'b1, z, z, z, z, z, z, z, z, z, 2'b00, 2'b00, 2'b10, z, z);
      default:    v = '0;
    endcase
    v[1] = err;
    return v;
  endfunction

  task automatic model_reset();
    plan.delete();
    plan.push_back(S_IDLE);
    m_wait = 0;
    m_err  = 1'b0;
  endtask

  // Model walks a per-instruction list of phases; waits and aborts are tracked abstractly.
  task automatic model_cycle(input logic rdy, input logic [5:0] op);
    logic [3:0] ph;
    exp_t       e;
    ph     = plan[0];
    e.st   = ph;
    e.ctrl = expect_ctrl(ph, rdy, op, m_err);
    sb_q.push_back(e);
    m_err = 1'b0;
    if (ph inside {S_FETCH, S_MEMREAD, S_MEMWRITE}) begin
      if (rdy) begin
        void'(plan.pop_front());
        m_wait = 0;
        if (ph == S_FETCH) plan.push_back(S_DECODE);
      end else if (m_wait == WAIT_MAX - 1) begin
        plan.delete();
        m_wait = 0;
        m_err  = 1'b1;
      end else begin
        m_wait++;
      end
    end else begin
      void'(plan.pop_front());
      if (ph == S_DECODE) begin
        case (op)
          6'b000000: begin plan.push_back(S_EXECUTE); plan.push_back(S_ALUWB); end
          6'b100011: begin plan.push_back(S_MEMADR); plan.push_back(S_MEMREAD); plan.push_back(S_MEMWB); end
          6'b101011: begin plan.push_back(S_MEMADR); plan.push_back(S_MEMWRITE); end
          6'b001000: begin plan.push_back(S_ADDIEX); plan.push_back(S_ADDIWB); end
          6'b000100: plan.push_back(S_BRANCH);
          6'b000010: plan.push_back(S_JUMP);
          6'b000101: if (TB_BNE) plan.push_back(S_BRANCH);
          default: ;
        endcase
      end
    end
    if (plan.size() == 0) plan.push_back(S_FETCH);
  endtask

  task automatic cycle(input logic rdy, input logic [5:0] op);
    @(negedge clk);
    rst_n         = 1'b1;
    bus.mem_ready = rdy;
    bus.opcode    = op;
    model_cycle(rdy, op);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n         = 1'b0;
    bus.mem_ready = 1'b1;
    bus.opcode    = 6'($urandom);
    repeat (n - 1) @(negedge clk);
    model_reset();
  endtask

  function automatic logic [18:0] actual_ctrl();
    logic bne;
`ifdef MCU_BNE_EN
    bne = bus.BranchNe;
`else
    bne = 1'b0;
`endif
    return {bus.PCWrite, bus.Branch, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite,
            bus.RegDst, bus.MemtoReg, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp,
            bus.PCSrc, bus.illegal_op, bus.mem_err, bne};
  endfunction

  initial begin : monitor
    exp_t        e;
    logic [18:0] act;
    int          cyc;
    cyc = 0;
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      if (sb_q.size() > 0) begin
        e   = sb_q.pop_front();
        act = actual_ctrl();
        n_checks++;
        if (bus.state_o !== e.st) begin
          n_fail++;
          $display("FAIL state cyc=%0d actual=%0d expected=%0d", cyc, bus.state_o, e.st);
        end
        n_checks++;
        if (act !== e.ctrl) begin
          n_fail++;
          $display("FAIL ctrl cyc=%0d state=%0d actual=%b expected=%b", cyc, e.st, act, e.ctrl);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : driver
    int stuck;
    int k;
    bus.mem_ready = 1'b1;
    bus.opcode    = 6'd0;
    do_reset(3);
    cycle(1'b1, 6'b100011);                          // IDLE
    repeat (5) cycle(1'b1, 6'b100011);               // lw, immediate ready
    repeat (3) cycle(1'b1, 6'b101011);               // sw with 3 stall cycles
    repeat (3) cycle(1'b0, 6'b101011);
    cycle(1'b1, 6'b101011);
    repeat (3) cycle(1'b1, 6'b100011);               // lw aborted in MEMREAD
    repeat (4) cycle(1'b0, 6'b100011);
    repeat (2) cycle(1'b1, 6'b111111);               // abort FETCH, then illegal in DECODE
    repeat (3) cycle(1'b1, 6'b000100);               // beq
    repeat (3) cycle(1'b1, 6'b000101);               // bne
    repeat (3) cycle(1'b1, 6'b000010);               // j
    repeat (4) cycle(1'b1, 6'b000000);               // R-type
    repeat (4) cycle(1'b1, 6'b001000);               // addi
    repeat (5) cycle(1'b0, 6'b000000);               // FETCH timeout re-enters FETCH
    repeat (3) cycle(1'b1, 6'b100011);
    cycle(1'b0, 6'b100011);                          // reset mid-access
    do_reset(2);
    cycle(1'b0, 6'b000000);

    stuck  = 0;
    cur_op = 6'd0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset($urandom_range(1, 3));
        continue;
      end
      if (plan[0] == S_DECODE) begin
        k      = $urandom_range(0, 8);
        cur_op = (k == 8) ? 6'($urandom) : op_tbl[k];
      end else if (plan[0] == S_FETCH || plan[0] == S_IDLE) begin
        cur_op = 6'($urandom);
      end
      if (stuck == 0 && $urandom_range(0, 39) == 0) stuck = $urandom_range(3, 6);
      if (stuck > 0) begin
        stuck--;
        cycle(1'b0, cur_op);
      end else begin
        cycle($urandom_range(0, 3) != 0, cur_op);
      end
    end

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    #5;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: scoreboard entries left actual=%0d expected=0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Next-generation MIPS control unit for the multicycle datapath.
- The single-cycle opcode decode is replaced by a Moore FSM that sequences FETCH/DECODE/EXECUTE/MEM/WB over several cycles.
- Stalls on a memory ready handshake, with a bounded wait watchdog.
- Sits between the instruction register's opcode field and the shared-ALU/shared-memory datapath muxes and enables.

Parameters:
- OPCODE_W, 6: opcode field width.
- WAIT_MAX, 15: max consecutive cycles waiting on mem_ready before abort (>=1).
- CNT_W, $clog2(WAIT_MAX+1): wait counter width (derived; do not override).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- opcode  in  OPCODE_W  instr[31:26] from the instruction register; stable from DECODE onward
- mem_ready  in  1  memory completes the current access this cycle
- PCWrite  out  1  unconditional PC load
- Branch  out  1  conditional PC load (qualified by ALU zero in datapath)
- IorD  out  1  memory address: 0=PC, 1=ALUOut
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction register load
- RegDst  out  1  write register: 0=rt, 1=rd
- MemtoReg  out  1  write data: 0=ALUOut, 1=MDR
- RegWrite  out  1  register file write
- ALUSrcA  out  1  0=PC, 1=rs
- ALUSrcB  out  2  00=rt, 01=4, 10=signext imm, 11=signext imm<<2
- ALUOp  out  2  00=add, 01=sub, 10=funct
- PCSrc  out  2  00=ALU, 01=ALUOut, 10=jump target
- illegal_op  out  1  unsupported opcode seen in DECODE
- mem_err  out  1  one-cycle pulse: memory wait aborted
- state_o  out  4  current state encoding (debug)

Behaviour:
- rst_n low at a clk edge: state<=S_IDLE, wait_cnt<=0, mem_err<=0. Reset mid-access aborts the access; no strobe is held.
- All outputs are zero in S_IDLE except state_o=S_IDLE.
- S_IDLE -> FETCH unconditionally; first fetch begins one cycle after reset release.
- Control outputs are Moore decodes of state. Unlisted outputs are 0.
- States and transitions:
  - FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00; IRWrite=PCWrite=mem_ready. mem_ready -> DECODE, else stay.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by opcode: 000000->EXECUTE, 100011/101011->MEMADR, 001000->ADDIEX, 000100->BRANCH, 000010->JUMP, other->FETCH with illegal_op=1 (combinational, this cycle only).
  - MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. lw->MEMREAD, sw->MEMWRITE.
  - MEMREAD: IorD=1, MemRead=1. mem_ready -> MEMWB, else stay.
  - MEMWB: RegDst=0, MemtoReg=1, RegWrite=1 -> FETCH.
  - MEMWRITE: IorD=1, MemWrite=1. mem_ready -> FETCH, else stay.
  - EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> ALUWB.
  - ALUWB: RegDst=1, RegWrite=1 -> FETCH.
  - ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> ADDIWB.
  - ADDIWB: RegDst=0, RegWrite=1 -> FETCH.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, Branch=1, PCSrc=01 -> FETCH.
  - JUMP: PCSrc=10, PCWrite=1 -> FETCH.
- Instruction latency in cycles with mem_ready immediate: R=4, addi=4, lw=5, sw=4, beq=3, j=3.
- Wait watchdog (FETCH, MEMREAD, MEMWRITE):
  - wait_cnt clears on every state change and increments each cycle mem_ready=0.
  - When wait_cnt==WAIT_MAX-1 and mem_ready=0, next state is FETCH and mem_err<=1 for one cycle.
  - A FETCH timeout re-enters FETCH with a fresh count.
  - No register or PC write occurs on abort.
  - mem_ready=1 in the timeout cycle: the access completes normally, no mem_err.
- Strobes, IorD and mux selects stay constant throughout a wait.
- opcode is ignored outside DECODE/MEMADR (and BRANCH when the optional feature is on).

Optional Feature:
- Macro: MCU_BNE_EN.
- Defined: opcode 000101 (bne) in DECODE -> BRANCH, and the extra output BranchNe (1 bit) is added. BranchNe=1 in BRANCH when the latched opcode is bne, else 0; Branch=1 only for beq.
- Undefined: port absent; 000101 is illegal (illegal_op=1, -> FETCH).

Decomposition:
- Package mips_ctrl_pkg holds:
  - opcode localparams: OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_BEQ, OP_J, OP_BNE
  - ALUOp, ALUSrcB and PCSrc encodings
  - state enum/localparams, 4 bits
- One natural sub-module: mcu_wait_timer (wait counter plus timeout compare, parametrised by WAIT_MAX).
- The FSM and output decode stay in the top module.

Test Plan:
- Reset: hold rst_n=0 three cycles with mem_ready=1, then release -> all outputs 0, state_o=S_IDLE; next cycle FETCH with MemRead=1, IRWrite=1, PCWrite=1.
- lw (opcode 100011), mem_ready=1 always -> state sequence FETCH,DECODE,MEMADR,MEMREAD,MEMWB; RegWrite=1 and MemtoReg=1 only in cycle 5.
- sw with mem_ready low for 3 cycles in MEMWRITE -> MemWrite=1, IorD=1 held 4 cycles, then FETCH; no mem_err.
- WAIT_MAX=4, mem_ready stuck 0 in MEMREAD -> after 4 cycles goes to FETCH, mem_err=1 exactly one cycle, RegWrite never 1.
- Opcode 111111 -> illegal_op=1 in DECODE, then FETCH; beq -> Branch=1, ALUOp=01, PCSrc=01 in cycle 3.
- MCU_BNE_EN defined, opcode 000101 -> BRANCH with BranchNe=1, Branch=0; undefined -> illegal_op=1.
